// File: rtl/cordic_result_packer_pkg.sv
// Shared types for the CORDIC back end: the final pipeline stage record, the
// 18-bit float layout and the rule that picks which CORDIC output is the result.
package cordic_result_packer_pkg;

  localparam int unsigned FX_W      = 17;  // [12:-4] two's complement
  localparam int unsigned FX_FRAC   = 4;
  localparam int unsigned FP_EXP_W  = 7;
  localparam int unsigned FP_MANT_W = 10;
  localparam int unsigned FP_W      = 1 + FP_EXP_W + FP_MANT_W;

  typedef enum logic [4:0] {
    FN_NOP   = 5'd0,
    FN_SIN   = 5'd1,
    FN_COS   = 5'd2,
    FN_ATAN  = 5'd3,
    FN_MAG   = 5'd4,
    FN_SINH  = 5'd5,
    FN_COSH  = 5'd6,
    FN_ATANH = 5'd7,
    FN_MUL   = 5'd8,
    FN_DIV   = 5'd9
  } func5_t;

  typedef enum logic {
    MODE_ROTATION  = 1'b0,
    MODE_VECTORING = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    COORD_CIRC = 2'd0,
    COORD_LIN  = 2'd1,
    COORD_HYP  = 2'd2
  } coord_t;

  typedef enum logic [1:0] {
    SEL_X = 2'd0,
    SEL_Y = 2'd1,
    SEL_Z = 2'd2
  } res_sel_t;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp18_t;

  typedef struct packed {
    logic                valid;
    func5_t              func;
    mode_t               mode;
    coord_t              coord;
    logic [FX_W-1:0]     x;
    logic [FX_W-1:0]     y;
    logic [FX_W-1:0]     z;
    logic                fp_sign;
    logic [FP_EXP_W-1:0] fp_exponent;
    logic                override;
    logic [FP_W-1:0]     override_val;
  } cordic_reg;

  // Vectoring leaves the angle in z; rotation leaves cos-type results in x and
  // sin-type results in y. The coordinate system does not affect the choice.
  function automatic res_sel_t cordic_result_sel(input func5_t func,
                                                 input mode_t  mode,
                                                 input coord_t coord);
    logic unused_coord;
    unused_coord = ^coord;
    if (mode == MODE_VECTORING)
      return SEL_Z;
    if (func == FN_SIN || func == FN_SINH)
      return SEL_Y;
    return SEL_X;
  endfunction

endpackage

// File: rtl/cordic_result_packer_fx2fp.sv
// Combinational fixed-point magnitude to 18-bit float conversion: leading-one
// detect, mantissa alignment, exponent rebias and underflow/overflow flagging.
module cordic_fx2fp
  import cordic_result_packer_pkg::*;
#(
  parameter int unsigned EXP_MAX = 127
) (
  input  logic                sign,
  input  logic [FX_W-1:0]     mag,
  input  logic [FP_EXP_W-1:0] fp_exponent,
  output fp18_t               result,
  output logic [1:0]          flags
);

  localparam logic signed [8:0] EXP_MAX_S = 9'(EXP_MAX);

  logic [4:0]        lead;
  logic [FX_W-1:0]   aligned;
  logic signed [8:0] exp_s;
  logic              unused_bits;

  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < FX_W; i++)
      if (mag[i]) lead = i[4:0];
  end

  // Leading one lands on the MSB; the next FP_MANT_W bits are the truncated mantissa.
  assign aligned     = mag << (5'(FX_W - 1) - lead);
  assign exp_s       = 9'(fp_exponent) + 9'(lead) - 9'(FX_FRAC);
  assign unused_bits = ^{aligned[FX_W-1], aligned[FX_W-FP_MANT_W-2:0]};

  always_comb begin
    result = '0;
    flags  = '0;
    if (mag == '0) begin
      result = '0;
    end else if (exp_s <= 9'sd0) begin
      result.sign = sign;
      flags       = 2'b01;
    end else if (exp_s >= EXP_MAX_S) begin
      result.sign = sign;
      result.exp  = '1;
      flags       = 2'b10;
    end else begin
      result.sign = sign;
      result.exp  = exp_s[FP_EXP_W-1:0];
      result.mant = aligned[FX_W-2 -: FP_MANT_W];
    end
  end

endmodule

// File: rtl/cordic_result_packer.sv
// CORDIC pipeline back end: selects the result operand, converts it to the
// 18-bit float format and presents it on a two-entry valid/ready output.
module cordic_result_packer
  import cordic_result_packer_pkg::*;
#(
  parameter int unsigned EXP_BIAS = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  cordic_reg   in_reg,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_data,
  output logic [4:0]  out_func,
  output logic [1:0]  out_flags
);

  res_sel_t        sel;
  logic [FX_W-1:0] operand;
  logic [FX_W-1:0] op_mag;

  logic                s1_valid;
  logic                s1_sign;
  logic [FX_W-1:0]     s1_mag;
  logic [FP_EXP_W-1:0] s1_exp;
  logic                s1_override;
  logic [FP_W-1:0]     s1_override_val;
  logic [4:0]          s1_func;

  logic  s1_load;
  logic  s2_load;
  fp18_t fp_res;
  logic [1:0] fx_flags;

  always_comb begin
    sel = cordic_result_sel(in_reg.func, in_reg.mode, in_reg.coord);
    case (sel)
      SEL_Y:   operand = in_reg.y;
      SEL_Z:   operand = in_reg.z;
      default: operand = in_reg.x;
    endcase
  end

  // Negating the most negative value yields 2^16, which still fits unsigned.
  assign op_mag = operand[FX_W-1] ? ((~operand) + FX_W'(1)) : operand;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1_sign         <= 1'b0;
      s1_mag          <= '0;
      s1_exp          <= '0;
      s1_override     <= 1'b0;
      s1_override_val <= '0;
      s1_func         <= '0;
    end else if (s1_load) begin
      s1_valid <= in_reg.valid;
      if (in_reg.valid) begin
        s1_sign         <= in_reg.fp_sign ^ operand[FX_W-1];
        s1_mag          <= op_mag;
        s1_exp          <= in_reg.fp_exponent;
        s1_override     <= in_reg.override;
        s1_override_val <= in_reg.override_val;
        s1_func         <= in_reg.func;
      end
    end
  end

  cordic_fx2fp #(
    .EXP_MAX (2 * EXP_BIAS + 1)
  ) u_fx2fp (
    .sign        (s1_sign),
    .mag         (s1_mag),
    .fp_exponent (s1_exp),
    .result      (fp_res),
    .flags       (fx_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_func  <= '0;
      out_flags <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= s1_override ? s1_override_val : fp_res;
        out_flags <= s1_override ? 2'b00 : fx_flags;
        out_func  <= s1_func;
      end
    end
  end

endmodule

// File: tb/tb_cordic_result_packer.sv
// Self-checking bench for cordic_result_packer: directed boundary vectors,
// stall/back-pressure, reset mid-stream and a randomized scoreboard run.
`timescale 1ns/1ps
module tb_cordic_result_packer;
  import cordic_result_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  cordic_reg   in_reg;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic [4:0]  out_func;
  logic [1:0]  out_flags;

  int n_cmp = 0;
  int n_err = 0;
  logic [24:0] exp_q[$];  // {func, flags, data}

  always #5 clk = ~clk;

  cordic_result_packer #(.EXP_BIAS(63)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_reg    (in_reg),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_func  (out_func),
    .out_flags (out_flags)
  );

  // Reference: real-valued magnitude, floor(log2) by repeated halving.
  function automatic logic [24:0] model(input cordic_reg r);
    logic [16:0] raw;
    int v, mag, p, e;
    logic s;
    logic [17:0] d;
    logic [1:0] f;
    if (r.mode == MODE_VECTORING) raw = r.z;
    else if (r.func == FN_SIN || r.func == FN_SINH) raw = r.y;
    else raw = r.x;
    v = raw[16] ? int'(raw) - 131072 : int'(raw);
    mag = (v < 0) ? -v : v;
    d = '0;
    f = '0;
    if (r.override) begin
      d = r.override_val;
    end else if (mag != 0) begin
      p = 0;
      while ((mag >> (p + 1)) != 0) p++;
      e = int'(r.fp_exponent) + p - 4;
      s = r.fp_sign ^ (v < 0);
      if (e <= 0) begin
        d = {s, 17'h0};
        f = 2'b01;
      end else if (e >= 127) begin
        d = {s, 7'h7F, 10'h0};
        f = 2'b10;
      end else begin
        d = {s, e[6:0], 10'((mag << 10) >> p)};
      end
    end
    return {r.func, f, d};
  endfunction

  function automatic logic [16:0] rand_fx();
    case ($urandom_range(0, 4))
      0:       return 17'($urandom);
      1:       return 17'($urandom_range(0, 40));
      2:       return 17'(-int'($urandom_range(1, 40)));
      3:       return ($urandom_range(0, 1) == 0) ? 17'h10000 : 17'h0FFFF;
      default: return 17'($urandom_range(0, 4095));
    endcase
  endfunction

  function automatic cordic_reg rand_in();
    cordic_reg r;
    r = '0;
    r.valid        = 1'b1;
    r.func         = func5_t'($urandom_range(0, 9));
    r.mode         = mode_t'($urandom_range(0, 1));
    r.coord        = coord_t'($urandom_range(0, 2));
    r.x            = rand_fx();
    r.y            = rand_fx();
    r.z            = rand_fx();
    r.fp_sign      = 1'($urandom_range(0, 1));
    r.fp_exponent  = 7'($urandom_range(0, 127));
    r.override     = ($urandom_range(0, 7) == 0);
    r.override_val = 18'($urandom);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_reg = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 18'h0) begin n_err++; $display("FAIL reset_data: got %h want 00000", out_data); end
    n_cmp++; if (out_func !== 5'h0) begin n_err++; $display("FAIL reset_func: got %h want 00", out_func); end
    n_cmp++; if (out_flags !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", out_flags); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    int unsigned sel_k[15] = '{0,0,0,0,0,0,0,1,2,0,0,0,0,0,0};
    logic [16:0] val[15] = '{17'h00010, 17'h1FFE8, 17'h1FFE8, 17'h1ABCD, 17'h0FFFF,
                             17'h00001, 17'h00000, 17'h00010, 17'h10000, 17'h1FFFF,
                             17'h00001, 17'h0FFFF, 17'h017FF, 17'h0FFFF, 17'h00000};
    logic [6:0] fe[15] = '{7'd63, 7'd63, 7'd63, 7'd127, 7'd120, 7'd2, 7'd63, 7'd63,
                           7'd63, 7'd4, 7'd5, 7'd115, 7'd63, 7'd116, 7'd63};
    logic fs[15] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
    logic [17:0] ed[15] = '{18'h0FC00, 18'h2FE00, 18'h0FE00, 18'h12345, 18'h1FC00,
                            18'h00000, 18'h00000, 18'h0FC00, 18'h32C00, 18'h20000,
                            18'h00400, 18'h1FBFF, 18'h11DFF, 18'h3FC00, 18'h00000};
    logic [1:0] ef[15] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'b10, 2'b01, 2'd0, 2'd0, 2'd0,
                           2'b01, 2'd0, 2'd0, 2'd0, 2'b10, 2'd0};
    cordic_reg r;
    for (int i = 0; i < 15; i++) begin
      r = rand_in();
      case (sel_k[i])
        1:       begin r.func = FN_SIN;  r.mode = MODE_ROTATION;  r.y = val[i]; end
        2:       begin r.func = FN_ATAN; r.mode = MODE_VECTORING; r.z = val[i]; end
        default: begin r.func = FN_COS;  r.mode = MODE_ROTATION;  r.x = val[i]; end
      endcase
      r.fp_exponent  = fe[i];
      r.fp_sign      = fs[i];
      r.override     = (i == 3);
      r.override_val = (i == 3) ? 18'h12345 : 18'($urandom);
      @(negedge clk);
      in_reg = r;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_reg.valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_early: out_valid got %b want 0", i, out_valid); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_latency: out_valid got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== ed[i]) begin n_err++; $display("FAIL dir%0d_data: got %h want %h", i, out_data, ed[i]); end
      n_cmp++; if (out_flags !== ef[i]) begin n_err++; $display("FAIL dir%0d_flags: got %b want %b", i, out_flags, ef[i]); end
      n_cmp++; if (out_func !== 5'(r.func)) begin n_err++; $display("FAIL dir%0d_func: got %h want %h", i, out_func, 5'(r.func)); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_dup: out_valid got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_stall();
    cordic_reg items[6];
    int sent = 0;
    int got = 0;
    int saw_block = 0;
    logic prev_stall = 1'b0;
    logic [24:0] held = '0;
    logic [24:0] want;
    for (int k = 0; k < 6; k++) items[k] = rand_in();
    exp_q.delete();
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 6);
      if (sent < 6) in_reg = items[sent];
      else in_reg.valid = 1'b0;
      #1;
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || {out_func, out_flags, out_data} !== held) begin
          n_err++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", out_valid, {out_func, out_flags, out_data}, held);
        end
      end
      if (!in_ready) begin
        saw_block = 1;
        n_cmp++; if (exp_q.size() != 2) begin n_err++; $display("FAIL stall_capacity: in_ready low with %0d held, want 2", exp_q.size()); end
      end
      if (out_valid && out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h1FFFFFF;
        got++;
        n_cmp++; if ({out_func, out_flags, out_data} !== want) begin n_err++; $display("FAIL stall_order%0d: got %h want %h", got, {out_func, out_flags, out_data}, want); end
      end
      if (in_reg.valid && in_ready) begin
        exp_q.push_back(model(in_reg));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      held = {out_func, out_flags, out_data};
    end
    n_cmp++; if (got != 6) begin n_err++; $display("FAIL stall_count: got %0d outputs want 6", got); end
    n_cmp++; if (saw_block != 1) begin n_err++; $display("FAIL stall_backpressure: in_ready never dropped, want a drop"); end
    @(negedge clk);
    in_reg.valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_random();
    int got = 0;
    int pushed = 0;
    logic prev_stall = 1'b0;
    logic [24:0] held = '0;
    logic [24:0] want;
    exp_q.delete();
    for (int c = 0; c < 450; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (c < 400 && $urandom_range(0, 9) < 7) in_reg = rand_in();
      else in_reg.valid = 1'b0;
      #1;
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || {out_func, out_flags, out_data} !== held) begin
          n_err++; $display("FAIL rand_hold: got v=%b %h want v=1 %h", out_valid, {out_func, out_flags, out_data}, held);
        end
      end
      if (out_valid && out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h1FFFFFF;
        got++;
        n_cmp++; if ({out_func, out_flags, out_data} !== want) begin n_err++; $display("FAIL rand_out%0d: got %h want %h", got, {out_func, out_flags, out_data}, want); end
      end
      if (in_reg.valid && in_ready) begin
        exp_q.push_back(model(in_reg));
        pushed++;
      end
      prev_stall = out_valid && !out_ready;
      held = {out_func, out_flags, out_data};
    end
    n_cmp++; if (got != pushed) begin n_err++; $display("FAIL rand_drain: got %0d outputs want %0d", got, pushed); end
    @(negedge clk);
    in_reg.valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midstream();
    cordic_reg r;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_reg = rand_in();
      in_reg.override = 1'b1;
      in_reg.override_val = 18'h3FFFF;
    end
    @(negedge clk);
    in_reg.valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 18'h0) begin n_err++; $display("FAIL mid_rst_data: got %h want 00000", out_data); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    r = rand_in();
    r.func = FN_COS;
    r.mode = MODE_ROTATION;
    r.x = 17'h00010;
    r.fp_exponent = 7'd63;
    r.fp_sign = 1'b0;
    r.override = 1'b0;
    in_reg = r;
    @(posedge clk);
    @(negedge clk);
    in_reg.valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale: out_valid got %b want 0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 18'h0FC00 || out_flags !== 2'b00) begin
      n_err++; $display("FAIL mid_first: got v=%b %h f=%b want v=1 0fc00 f=00", out_valid, out_data, out_flags);
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_extra: out_valid got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
